memory_arbiter: RTL and testbench

Shares the z8 core's single-ported synchronous memory between three requesters: instruction fetch (F), data access from the control unit (D) and the switch-driven program loader (L). It sits between the core and the memory array and sequences every access through a three-state handshake FSM. Priority is fixed (D > F > L), with a starvation counter that promotes L when it has waited too long.

---
 rtl/instruction_set_pkg.sv | 25 ++
 rtl/memory_arbiter_priority_select.sv | 26 ++
 rtl/memory_arbiter.sv | 171 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_set_pkg.sv
// Shared z8 core types: memory-arbiter FSM states, requester ids and the
// default starvation threshold, plus the saturating helper for the wait counter.
package instruction_set;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_COMPLETE = 2'd2
    } ARB_STATE_T;

    typedef enum logic [1:0] {
        REQ_NONE   = 2'd0,
        REQ_FETCH  = 2'd1,
        REQ_DATA   = 2'd2,
        REQ_LOADER = 2'd3
    } REQUESTER_T;

    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int L_WAIT_WIDTH         = 4;

    function automatic logic [L_WAIT_WIDTH-1:0] sat_inc(input logic [L_WAIT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/memory_arbiter_priority_select.sv
// Fixed-priority winner selection (D > F > L) with a starvation override
// that lets a waiting loader jump the queue.
module arb_priority_select
    import instruction_set::*;
(
    input  logic       f_req,
    input  logic       d_req,
    input  logic       l_req,
    input  logic       starve,
    output REQUESTER_T winner
);

    always_comb begin
        winner = REQ_NONE;
        if (starve && l_req) begin
            winner = REQ_LOADER;
        end else if (d_req) begin
            winner = REQ_DATA;
        end else if (f_req) begin
            winner = REQ_FETCH;
        end else if (l_req) begin
            winner = REQ_LOADER;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Three-way arbiter for the z8 single-ported synchronous memory: every access
// runs IDLE (arbitrate) -> ISSUE (strobe) -> COMPLETE (ack + read data).
module memory_arbiter
    import instruction_set::*;
#(
    parameter int WORD_SIZE    = 8,
    parameter int ADDR_SIZE    = 8,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_req,
    input  logic                 f_we,
    input  logic [ADDR_SIZE-1:0] f_addr,
    input  logic [WORD_SIZE-1:0] f_wdata,
    output logic                 f_ack,
    output logic [WORD_SIZE-1:0] f_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    input  logic                 l_req,
    input  logic                 l_we,
    input  logic [ADDR_SIZE-1:0] l_addr,
    input  logic [WORD_SIZE-1:0] l_wdata,
    output logic                 l_ack,
    output logic [WORD_SIZE-1:0] l_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy,
    output logic [1:0]           grant_id
);

    localparam logic [L_WAIT_WIDTH-1:0] STARVE_THRESH = L_WAIT_WIDTH'(STARVE_LIMIT);

    ARB_STATE_T                state_q, state_d;
    REQUESTER_T                owner_q, owner_d;
    logic                      we_q, we_d;
    logic [ADDR_SIZE-1:0]      addr_q, addr_d;
    logic [WORD_SIZE-1:0]      wdata_q, wdata_d;
    logic [L_WAIT_WIDTH-1:0]   l_wait_q, l_wait_d;

    logic                      mem_en_q, mem_en_d;
    logic                      mem_we_q, mem_we_d;
    logic [ADDR_SIZE-1:0]      mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]      mem_wdata_q, mem_wdata_d;
    logic                      busy_q, busy_d;
    REQUESTER_T                grant_q, grant_d;
    logic [2:0]                ack_q, ack_d;

    logic [2:0]                ack_vec;
    logic [WORD_SIZE-1:0]      rdata_vec [3];

    REQUESTER_T                winner;
    logic                      starve;

    assign starve = (l_wait_q >= STARVE_THRESH);

    arb_priority_select u_select (
        .f_req  (f_req),
        .d_req  (d_req),
        .l_req  (l_req),
        .starve (starve),
        .winner (winner)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        l_wait_d = l_wait_q;
        unique case (state_q)
            ARB_IDLE: begin
                case (winner)
                    REQ_FETCH: begin
                        we_d = f_we; addr_d = f_addr; wdata_d = f_wdata;
                    end
                    REQ_DATA: begin
                        we_d = d_we; addr_d = d_addr; wdata_d = d_wdata;
                    end
                    REQ_LOADER: begin
                        we_d = l_we; addr_d = l_addr; wdata_d = l_wdata;
                    end
                    default: ;
                endcase
                if (winner != REQ_NONE) begin
                    owner_d = winner;
                    state_d = ARB_ISSUE;
                end
                // A loss only counts while L is actually asking; any idle gap clears it.
                if (winner == REQ_LOADER || !l_req) begin
                    l_wait_d = '0;
                end else begin
                    l_wait_d = sat_inc(l_wait_q);
                end
            end
            ARB_ISSUE:    state_d = ARB_COMPLETE;
            ARB_COMPLETE: state_d = ARB_IDLE;
            default:      state_d = ARB_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they come straight off flops.
    always_comb begin
        mem_en_d    = (state_d == ARB_ISSUE);
        mem_we_d    = mem_en_d && we_d;
        mem_addr_d  = mem_en_d ? addr_d : '0;
        mem_wdata_d = mem_en_d ? wdata_d : '0;
        busy_d      = (state_d != ARB_IDLE);
        grant_d     = (state_d == ARB_IDLE) ? REQ_NONE : owner_d;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_req
        assign ack_d[gi]     = (state_d == ARB_COMPLETE) && (owner_d == REQUESTER_T'(2'(gi + 1)));
        assign ack_vec[gi]   = ack_q[gi] && !reset;
        assign rdata_vec[gi] = (ack_vec[gi] && !we_q) ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= REQ_NONE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            l_wait_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            grant_q     <= REQ_NONE;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            l_wait_q    <= l_wait_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign f_ack     = ack_vec[0];
    assign d_ack     = ack_vec[1];
    assign l_ack     = ack_vec[2];
    assign f_rdata   = rdata_vec[0];
    assign d_rdata   = rdata_vec[1];
    assign l_rdata   = rdata_vec[2];

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a transaction-schedule model is checked
// every cycle, and literal expectations pin the documented scenarios.
module tb_memory_arbiter;

    localparam int NC = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       f_req = 0, f_we = 0, d_req = 0, d_we = 0, l_req = 0, l_we = 0;
    logic [7:0] f_addr = 0, f_wdata = 0, d_addr = 0, d_wdata = 0, l_addr = 0, l_wdata = 0;
    logic       f_ack, d_ack, l_ack, mem_en, mem_we, busy;
    logic [7:0] f_rdata, d_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0] grant_id;

    logic [7:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    memory_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    // Synchronous single-port memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- model: schedule of expected outputs per cycle ----------------
    int  e_en[NC], e_we[NC], e_addr[NC], e_wdata[NC], e_busy[NC], e_grant[NC];
    int  e_own[NC], e_rd[NC], e_raddr[NC];
    int  shadow[256];
    bit  armed = 0;
    int  arm_cycle = 0;
    int  next_free = 0;
    int  lwait = 0;

    function automatic int pick(input int lw);
        if (l_req && lw >= 4) return 3;
        if (d_req) return 2;
        if (f_req) return 1;
        if (l_req) return 3;
        return 0;
    endfunction

    task automatic clear_slot(input int k);
        e_en[k] = 0; e_we[k] = 0; e_addr[k] = 0; e_wdata[k] = 0; e_busy[k] = 0;
        e_grant[k] = 0; e_own[k] = 0; e_rd[k] = 0; e_raddr[k] = 0;
    endtask

    always @(negedge clk) begin : model
        int c, win, wwe, wad, wwd, ea;
        logic [2:0] acks;
        logic [7:0] rds [3];
        c = cyc;
        if (c + 2 < NC) begin
            if (armed && c >= arm_cycle) begin
                acks = {l_ack, d_ack, f_ack};
                rds[0] = f_rdata; rds[1] = d_rdata; rds[2] = l_rdata;
                chk("busy", busy, e_busy[c]);
                chk("grant_id", grant_id, e_grant[c]);
                chk("mem_en", mem_en, e_en[c]);
                chk("mem_we", mem_we, e_we[c]);
                chk("mem_addr", mem_addr, e_addr[c]);
                chk("mem_wdata", mem_wdata, e_wdata[c]);
                for (int i = 0; i < 3; i++) begin
                    ea = (e_own[c] == i + 1 && !reset) ? 1 : 0;
                    chk($sformatf("ack[%0d]", i), acks[i], ea);
                    chk($sformatf("rdata[%0d]", i), rds[i],
                        (ea != 0 && e_rd[c] != 0) ? shadow[e_raddr[c]] : 0);
                end
            end
            if (e_en[c] != 0 && e_we[c] != 0) shadow[e_addr[c]] = e_wdata[c];
            if (reset) begin
                if (!armed) begin
                    armed = 1;
                    arm_cycle = c + 1;
                end
                clear_slot(c + 1);
                clear_slot(c + 2);
                next_free = c + 1;
                lwait = 0;
            end else if (armed && c >= next_free) begin
                win = pick(lwait);
                if (win != 0) begin
                    wwe = (win == 1) ? f_we    : (win == 2) ? d_we    : l_we;
                    wad = (win == 1) ? f_addr  : (win == 2) ? d_addr  : l_addr;
                    wwd = (win == 1) ? f_wdata : (win == 2) ? d_wdata : l_wdata;
                    e_en[c+1] = 1; e_we[c+1] = wwe; e_addr[c+1] = wad; e_wdata[c+1] = wwd;
                    e_busy[c+1] = 1; e_grant[c+1] = win;
                    e_busy[c+2] = 1; e_grant[c+2] = win; e_own[c+2] = win;
                    e_rd[c+2] = (wwe == 0) ? 1 : 0; e_raddr[c+2] = wad;
                    next_free = c + 3;
                end
                if (win == 3 || !l_req) lwait = 0;
                else if (lwait < 15) lwait = lwait + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int k);
        d_req = 1; d_we = 1;
        d_addr  = 8'(8'h50 + k);
        d_wdata = 8'(8'hD0 + k);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish (got running, expected done)");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            shadow[i] = i * 7 + 3;
        end
        mem[8'h10] = 8'h3C;
        shadow[8'h10] = 8'h3C;

        repeat (3) tick();
        reset = 0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_acks", {f_ack, d_ack, l_ack}, 0);

        // Single read of 0x10
        f_req = 1; f_we = 0; f_addr = 8'h10;
        tick();
        chk("s1_mem_en", mem_en, 1);
        chk("s1_mem_addr", mem_addr, 8'h10);
        chk("s1_mem_we", mem_we, 0);
        chk("s1_busy_c1", busy, 1);
        chk("s1_grant", grant_id, 1);
        tick();
        chk("s1_f_ack", f_ack, 1);
        chk("s1_f_rdata", f_rdata, 8'h3C);
        chk("s1_busy_c2", busy, 1);
        f_req = 0;
        tick();
        chk("s1_busy_c3", busy, 0);
        chk("s1_rdata_idle", f_rdata, 0);

        // Collision: D write wins, then F reads 0x21 and then 0x20
        set_d(0); d_addr = 8'h20; d_wdata = 8'hAA;
        f_req = 1; f_we = 0; f_addr = 8'h21;
        tick();
        chk("s2_grant_d", grant_id, 2);
        chk("s2_mem_we", mem_we, 1);
        chk("s2_mem_wdata", mem_wdata, 8'hAA);
        tick();
        chk("s2_d_ack", d_ack, 1);
        chk("s2_f_ack_lost", f_ack, 0);
        d_req = 0;
        tick();
        tick();
        chk("s2_grant_f", grant_id, 1);
        chk("s2_mem_addr_f", mem_addr, 8'h21);
        chk("s2_mem20", mem[8'h20], 8'hAA);
        tick();
        chk("s2_f_ack", f_ack, 1);
        chk("s2_f_rdata", f_rdata, 8'hEA);
        f_addr = 8'h20;
        tick();
        tick();
        tick();
        chk("s2_f_rdata_20", f_rdata, 8'hAA);
        f_req = 0;
        tick();

        // Starvation: D re-requests after each ack; L wins at the fifth arbitration
        set_d(0);
        l_req = 1; l_we = 0; l_addr = 8'h10;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s3_d_wins", grant_id, 2);
            tick();
            chk("s3_l_ack_lost", l_ack, 0);
            set_d(k + 1);
            tick();
        end
        tick();
        chk("s3_l_grant", grant_id, 3);
        tick();
        chk("s3_l_ack", l_ack, 1);
        chk("s3_l_rdata", l_rdata, 8'h3C);
        l_addr = 8'h11;
        tick();
        tick();
        chk("s3_wait_cleared", grant_id, 2);
        tick();
        d_req = 0;
        tick();
        tick();
        chk("s3_l_second", grant_id, 3);
        tick();
        l_req = 0;
        tick();

        // Counter clear: three losses, one idle gap without l_req, then four more
        set_d(0);
        l_req = 1; l_addr = 8'h12;
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            set_d(k + 1);
            tick();
        end
        l_req = 0;
        tick();
        l_req = 1;
        tick();
        set_d(4);
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s4_d_after_clear", grant_id, 2);
            tick();
            set_d(5 + k);
            tick();
        end
        tick();
        chk("s4_l_grant", grant_id, 3);
        tick();
        chk("s4_l_ack", l_ack, 1);
        l_req = 0;
        tick();
        tick();
        tick();
        d_req = 0;
        tick();

        // Reset during ISSUE of a D write
        set_d(0); d_addr = 8'h30; d_wdata = 8'h55;
        tick();
        chk("s5_issue", mem_en, 1);
        reset = 1; d_req = 0;
        tick();
        reset = 0;
        chk("s5_outputs_zero", {busy, grant_id, mem_en, mem_we, mem_addr, mem_wdata, f_ack, d_ack, l_ack}, 0);
        chk("s5_mem30", mem[8'h30], 8'h55);
        tick();
        chk("s5_no_d_ack", d_ack, 0);
        tick();

        // Reset during COMPLETE of an F read
        f_req = 1; f_we = 0; f_addr = 8'h10;
        tick();
        tick();
        reset = 1;
        #1;
        chk("s5b_ack_suppressed", f_ack, 0);
        f_req = 0;
        tick();
        reset = 0;
        chk("s5b_busy", busy, 0);
        tick();

        // Glitch on f_req while D owns the memory
        set_d(0); d_addr = 8'h60; d_wdata = 8'h11;
        tick();
        f_req = 1; f_addr = 8'h70;
        tick();
        f_req = 0;
        chk("s6_d_ack", d_ack, 1);
        d_req = 0;
        tick();
        tick();
        chk("s6_no_issue", mem_en, 0);
        tick();
        chk("s6_no_f_ack", f_ack, 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
